inst_fetch: RTL and testbench

- Instruction-fetch stage and initiator toward the instruction ROM.
- Owns the PC and drives the ROM chip-enable and address; the ROM returns the addressed word combinationally in the same cycle.
- Registers PC, instruction and valid into the IF/ID boundary.
- Applies stall, branch/jump redirect and exception/eret flush with fixed priority. No branch delay slot: a redirect squashes the word being fetched.

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch_pc_reg.sv | 61 ++++++
 rtl/inst_fetch.sv | 103 ++++++++++
 tb/tb_inst_fetch.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types, constants and helpers for the instruction-fetch stage
package inst_fetch_pkg;

    localparam int INST_W = 32;
    localparam int IADDR_W = 32;

    typedef logic [IADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]  inst_t;

    localparam logic       ROM_ENABLE       = 1'b1;
    localparam logic       ROM_DISABLE      = 1'b0;
    localparam inst_t      ZERO_WORD        = '0;
    localparam inst_addr_t DEFAULT_RESET_PC = 32'h0000_0000;

    // Which source the PC takes at the next edge; the IF/ID register follows the same choice.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_FLUSH  = 2'd3
    } pc_sel_e;

    function automatic logic is_aligned(input inst_addr_t addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/inst_fetch_pc_reg.sv
// rtl/inst_fetch_pc_reg.sv - PC register, ROM enable generation and next-PC priority mux
module inst_fetch_pc_reg
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_taken_i,
    input  logic [ADDR_W-1:0] br_target_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
    output pc_sel_e           sel_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q;
    pc_sel_e           sel;

    // Priority: flush beats branch beats stall; nothing is honoured until the enable is up.
    always_comb begin
        sel = SEL_HOLD;
        if (ce_q == ROM_ENABLE) begin
            if (flush_i)         sel = SEL_FLUSH;
            else if (br_taken_i) sel = SEL_BRANCH;
            else if (stall_i)    sel = SEL_HOLD;
            else                 sel = SEL_SEQ;
        end
    end

    // Next-PC mux; sequential step wraps naturally at the top of the address space.
    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_FLUSH:  pc_d = flush_pc_i;
            SEL_BRANCH: pc_d = br_target_i;
            SEL_SEQ:    pc_d = pc_q + ADDR_W'(4);
            default:    pc_d = pc_q;
        endcase
    end

    // PC and enable registers; the enable rises one edge after reset so the first fetch is RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC[ADDR_W-1:0];
            ce_q <= ROM_DISABLE;
        end else begin
            pc_q <= pc_d;
            ce_q <= ROM_ENABLE;
        end
    end

    assign pc_o  = pc_q;
    assign ce_o  = ce_q;
    assign sel_o = sel;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction-fetch stage with IF/ID boundary register
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_inst,
    output logic              if_valid,
    output logic              if_adel
);

    logic              ce;
    logic              aligned;
    pc_sel_e           sel;

    logic [ADDR_W-1:0] if_pc_q, if_pc_d;
    inst_t             if_inst_q, if_inst_d;
    logic              if_valid_q, if_valid_d;
    logic              if_adel_q, if_adel_d;

    inst_fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .ADDR_W   (ADDR_W)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .flush_i     (flush),
        .flush_pc_i  (flush_pc),
        .pc_o        (pc),
        .ce_o        (ce),
        .sel_o       (sel)
    );

    assign aligned  = is_aligned(inst_addr_t'(pc));
    assign rom_addr = pc;
    // A misaligned PC still drives the address but never enables the ROM.
    assign rom_ce   = ce & aligned;

    // IF/ID next state: a redirect squashes the word in flight, a misaligned fetch becomes an address-error bubble.
    always_comb begin
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        if_adel_d  = if_adel_q;
        case (sel)
            SEL_FLUSH: begin
                if_inst_d  = ZERO_WORD;
                if_valid_d = 1'b0;
                if_adel_d  = 1'b0;
            end
            SEL_BRANCH: begin
                if_pc_d    = pc;
                if_inst_d  = ZERO_WORD;
                if_valid_d = 1'b0;
                if_adel_d  = 1'b0;
            end
            SEL_SEQ: begin
                if_pc_d    = pc;
                if_valid_d = 1'b1;
                if_inst_d  = aligned ? rom_data : ZERO_WORD;
                if_adel_d  = ~aligned;
            end
            default: ;
        endcase
    end

    // IF/ID boundary register.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_pc_q    <= '0;
            if_inst_q  <= ZERO_WORD;
            if_valid_q <= 1'b0;
            if_adel_q  <= 1'b0;
        end else begin
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            if_adel_q  <= if_adel_d;
        end
    end

    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;
    assign if_adel  = if_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch against a behavioural fetch model
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_adel;

    logic [31:0] rom [0:63];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic        ce;
        logic [31:0] if_pc;
        logic [31:0] if_inst;
        logic        v;
        logic        adel;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state: the fetch engine seen from outside.
    logic [31:0] m_pc;
    logic        m_on;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_inst;
    logic        m_v;
    logic        m_adel;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[7:2]];

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_ce    (rom_ce),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .pc        (pc),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .if_adel   (if_adel)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by one edge and queue the expected state.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic f, input logic [31:0] fp);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; br_taken = b; br_target = t; flush = f; flush_pc = fp;
        if (r) begin
            m_pc = 32'h0; m_on = 1'b0;
            m_if_pc = 32'h0; m_if_inst = 32'h0; m_v = 1'b0; m_adel = 1'b0;
        end else if (!m_on) begin
            m_on = 1'b1;
        end else if (f) begin
            m_pc = fp; m_if_inst = 32'h0; m_v = 1'b0; m_adel = 1'b0;
        end else if (b) begin
            m_if_pc = m_pc; m_pc = t; m_if_inst = 32'h0; m_v = 1'b0; m_adel = 1'b0;
        end else if (!s) begin
            m_if_pc = m_pc;
            m_v = 1'b1;
            if (m_pc % 4 == 0) begin
                m_if_inst = rom[(m_pc / 4) % 64];
                m_adel = 1'b0;
            end else begin
                m_if_inst = 32'h0;
                m_adel = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.ce = m_on && (m_pc % 4 == 0);
        e.if_pc = m_if_pc; e.if_inst = m_if_inst; e.v = m_v; e.adel = m_adel;
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: after every edge, compare the DUT against the oldest queued expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pc", pc, e.pc);
            chk("rom_addr", rom_addr, e.pc);
            chk("rom_ce", {31'b0, rom_ce}, {31'b0, e.ce});
            chk("if_pc", if_pc, e.if_pc);
            chk("if_inst", if_inst, e.if_inst);
            chk("if_valid", {31'b0, if_valid}, {31'b0, e.v});
            chk("if_adel", {31'b0, if_adel}, {31'b0, e.adel});
        end
    end

    initial begin
        logic [31:0] t;
        logic [31:0] fp;
        for (int i = 0; i < 64; i++) rom[i] = $urandom;
        rom[0] = 32'h34011100;
        rom[1] = 32'h34020020;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; flush = 1'b0; flush_pc = '0;
        m_pc = '0; m_on = 1'b0; m_if_pc = '0; m_if_inst = '0; m_v = 1'b0; m_adel = 1'b0;

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        run(4);
        // stall three cycles at pc 0x10, then release
        run(0);
        while (m_pc != 32'h10) run(1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        run(3);
        // branch from 0x44 to 0x48
        cyc(1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h48, 1'b0, 32'h0);
        run(2);
        // flush, branch and stall together: flush wins
        cyc(1'b0, 1'b1, 1'b1, 32'h48, 1'b1, 32'h80);
        run(2);
        // misaligned branch target
        cyc(1'b0, 1'b0, 1'b1, 32'h22, 1'b0, 32'h0);
        run(2);
        // reset during a stall at 0x40
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        run(3);
        // wrap at the top of the address space
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        run(4);

        for (int i = 0; i < 3000; i++) begin
            t  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : (32'($urandom_range(0, 63)) << 2);
            fp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 255));
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, t,
                $urandom_range(0, 11) == 0, fp);
        end
        run(2);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
